// File: rtl/axis_frame_loader.sv
// rtl/axis_frame_loader.sv - assembles a WORDS-beat stream into one wide parallel frame
//
// Receives DATA_W-bit beats from a DMA MM2S stream and packs WORDS of them
// into a FRAME_W-bit frame; beat k lands in frame_data[k*DATA_W +: DATA_W].
// Beats are collected in a shadow buffer and frame_data is only updated when
// a complete frame (tlast exactly on beat WORDS-1) has arrived.
//
// Optional feature: define FRAME_ACK_EN to hold off the stream after each
// good frame until the consumer pulses frame_ack.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   enable          permit reception; sampled only at frame boundaries
//   M_AXIS_*        stream input (tvalid/tready/tlast/tdata)
//   frame_ack       consumer acknowledge (FRAME_ACK_EN only)
//   frame_data      last complete frame
//   frame_valid     1-cycle pulse when frame_data updates
//   frame_err       1-cycle pulse on a short or long packet
//   frame_cnt       good frame count, wraps

module axis_frame_loader #(
  parameter  int DATA_W  = 32,
  parameter  int WORDS   = 256,
  localparam int FRAME_W = DATA_W * WORDS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               M_AXIS_tvalid,
  output logic               M_AXIS_tready,
  input  logic               M_AXIS_tlast,
  input  logic [DATA_W-1:0]  M_AXIS_tdata,
  input  logic               frame_ack,
  output logic [FRAME_W-1:0] frame_data,
  output logic               frame_valid,
  output logic               frame_err,
  output logic [15:0]        frame_cnt
);

  localparam int IDX_W = $clog2(WORDS);

`ifdef FRAME_ACK_EN
  typedef enum logic [1:0] {IDLE, RECV, DRAIN, HOLD} state_t;
`else
  typedef enum logic [1:0] {IDLE, RECV, DRAIN} state_t;
  logic unused_frame_ack;
  assign unused_frame_ack = frame_ack;
`endif

  state_t             state, state_next;
  logic [IDX_W-1:0]   idx;
  logic [FRAME_W-1:0] shadow;

  logic take, last_word, recv_take, good, short_f, long_f;
  state_t after_frame;

  assign take      = M_AXIS_tvalid && M_AXIS_tready;
  assign last_word = (idx == IDX_W'(WORDS - 1));
  assign recv_take = (state == RECV) && take;
  assign good      = recv_take &&  M_AXIS_tlast &&  last_word;
  assign short_f   = recv_take &&  M_AXIS_tlast && !last_word;
  assign long_f    = recv_take && !M_AXIS_tlast &&  last_word;
  // enable is only looked at here, i.e. once a packet has finished
  assign after_frame = enable ? RECV : IDLE;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (enable) state_next = RECV;
      RECV: begin
        if (good) begin
`ifdef FRAME_ACK_EN
          state_next = HOLD;
`else
          state_next = after_frame;
`endif
        end else if (short_f) begin
          state_next = after_frame;
        end else if (long_f) begin
          state_next = DRAIN;
        end
      end
      DRAIN: if (take && M_AXIS_tlast) state_next = after_frame;
`ifdef FRAME_ACK_EN
      // The HOLD entry cycle is also the frame_valid cycle, so an ack
      // presented together with frame_valid releases immediately.
      HOLD:  if (frame_ack) state_next = after_frame;
`endif
      default: state_next = IDLE;
    endcase
  end

  // tready is registered from the next state so it is glitch-free and
  // already correct in the first cycle of RECV/DRAIN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      M_AXIS_tready <= 1'b0;
    end else begin
      state         <= state_next;
      M_AXIS_tready <= (state_next == RECV) || (state_next == DRAIN);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx         <= '0;
      shadow      <= '0;
      frame_data  <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      frame_valid <= good;
      frame_err   <= short_f || long_f;
      if (recv_take) begin
        shadow[idx*DATA_W +: DATA_W] <= M_AXIS_tdata;
        idx <= (M_AXIS_tlast || last_word) ? '0 : idx + IDX_W'(1);
      end
      if (good) begin
        // The final beat is always the top word, so merge it directly
        // rather than waiting a cycle for the shadow write to land.
        frame_data <= {M_AXIS_tdata, shadow[FRAME_W-DATA_W-1:0]};
        frame_cnt  <= frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_axis_frame_loader.sv
// tb/tb_axis_frame_loader.sv - directed self-checking bench for axis_frame_loader

module tb_axis_frame_loader;

  localparam int DATA_W  = 32;
  localparam int WORDS   = 256;
  localparam int FRAME_W = DATA_W * WORDS;

  logic               clk = 1'b0;
  logic               rst;
  logic               enable;
  logic               M_AXIS_tvalid;
  logic               M_AXIS_tready;
  logic               M_AXIS_tlast;
  logic [DATA_W-1:0]  M_AXIS_tdata;
  logic               frame_ack;
  logic [FRAME_W-1:0] frame_data;
  logic               frame_valid;
  logic               frame_err;
  logic [15:0]        frame_cnt;

  always #5 clk = ~clk;

  axis_frame_loader #(.DATA_W(DATA_W), .WORDS(WORDS)) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .M_AXIS_tvalid (M_AXIS_tvalid),
    .M_AXIS_tready (M_AXIS_tready),
    .M_AXIS_tlast  (M_AXIS_tlast),
    .M_AXIS_tdata  (M_AXIS_tdata),
    .frame_ack     (frame_ack),
    .frame_data    (frame_data),
    .frame_valid   (frame_valid),
    .frame_err     (frame_err),
    .frame_cnt     (frame_cnt)
  );

  int checks = 0;
  int errors = 0;
  int both_cnt = 0;
  int v_cnt, e_cnt, v_at, e_at, stalls;

  always @(negedge clk) if (frame_valid && frame_err) both_cnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] word_of(input int k);
    return frame_data[k*DATA_W +: DATA_W];
  endfunction

  function automatic int count_bad(input logic [31:0] base);
    int bad = 0;
    for (int k = 0; k < WORDS; k++)
      if (frame_data[k*DATA_W +: DATA_W] !== 32'(base + 32'(k))) bad++;
    return bad;
  endfunction

  // Drives n beats (data base+k, tlast on beat tl_at; -1 = none) and records
  // frame_valid / frame_err pulses against the index of the beat that caused them.
  task automatic send_beats(input int n, input int tl_at, input logic [31:0] base, input bit gaps);
    int k = 0;
    int cyc = 0;
    v_cnt = 0; e_cnt = 0; v_at = -1; e_at = -1; stalls = 0;
    while (k < n && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (frame_valid) begin v_cnt++; v_at = k - 1; end
      if (frame_err)   begin e_cnt++; e_at = k - 1; end
      M_AXIS_tvalid = !(gaps && ($urandom_range(0, 99) < 30));
      M_AXIS_tdata  = base + 32'(k);
      M_AXIS_tlast  = (k == tl_at);
      if (M_AXIS_tvalid && !M_AXIS_tready) stalls++;
      if (M_AXIS_tvalid &&  M_AXIS_tready) k++;
    end
    @(negedge clk);
    if (frame_valid) begin v_cnt++; v_at = k - 1; end
    if (frame_err)   begin e_cnt++; e_at = k - 1; end
    M_AXIS_tvalid = 1'b0;
    M_AXIS_tlast  = 1'b0;
    checks++;
    if (k != n) begin errors++; $display("FAIL send_timeout: sent %0d beats, required %0d", k, n); end
  endtask

  task automatic test_reset();
    rst = 1'b0; enable = 1'b0; M_AXIS_tvalid = 1'b0; M_AXIS_tlast = 1'b0;
    M_AXIS_tdata = '0; frame_ack = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (M_AXIS_tready !== 1'b0) begin errors++; $display("FAIL rst_tready: got %b, want 0", M_AXIS_tready); end
    checks++; if (frame_data !== '0) begin errors++; $display("FAIL rst_data: got nonzero, want 0"); end
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b, want 0", frame_valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b, want 0", frame_err); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL rst_cnt: got %0d, want 0", frame_cnt); end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (M_AXIS_tready !== 1'b0) begin errors++; $display("FAIL idle_tready: got %b, want 0", M_AXIS_tready); end
    enable = 1'b1;
    @(negedge clk);
    checks++; if (M_AXIS_tready !== 1'b1) begin errors++; $display("FAIL recv_tready: got %b, want 1", M_AXIS_tready); end
  endtask

  task automatic test_good_frame();
    send_beats(256, 255, 32'h100, 1'b0);
    checks++; if (v_cnt != 1) begin errors++; $display("FAIL good_vcnt: got %0d, want 1", v_cnt); end
    checks++; if (v_at != 255) begin errors++; $display("FAIL good_vat: got %0d, want 255", v_at); end
    checks++; if (e_cnt != 0) begin errors++; $display("FAIL good_ecnt: got %0d, want 0", e_cnt); end
    checks++; if (word_of(0) !== 32'h100) begin errors++; $display("FAIL good_w0: got %h, want 00000100", word_of(0)); end
    checks++; if (word_of(255) !== 32'h1FF) begin errors++; $display("FAIL good_w255: got %h, want 000001ff", word_of(255)); end
    checks++; if (count_bad(32'h100) != 0) begin errors++; $display("FAIL good_words: %0d bad words, want 0", count_bad(32'h100)); end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL good_cnt: got %0d, want 1", frame_cnt); end
    @(negedge clk);
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL good_pulse: valid %b one cycle later, want 0", frame_valid); end
  endtask

  task automatic test_gaps();
    send_beats(256, 255, 32'h900, 1'b1);
    checks++; if (v_cnt != 1) begin errors++; $display("FAIL gaps_vcnt: got %0d, want 1", v_cnt); end
    checks++; if (count_bad(32'h900) != 0) begin errors++; $display("FAIL gaps_words: %0d bad words, want 0", count_bad(32'h900)); end
    checks++; if (frame_cnt !== 16'd2) begin errors++; $display("FAIL gaps_cnt: got %0d, want 2", frame_cnt); end
  endtask

  task automatic test_short();
    send_beats(100, 99, 32'h5000, 1'b0);
    checks++; if (e_cnt != 1) begin errors++; $display("FAIL short_ecnt: got %0d, want 1", e_cnt); end
    checks++; if (e_at != 99) begin errors++; $display("FAIL short_eat: got %0d, want 99", e_at); end
    checks++; if (v_cnt != 0) begin errors++; $display("FAIL short_vcnt: got %0d, want 0", v_cnt); end
    checks++; if (word_of(50) !== 32'h932) begin errors++; $display("FAIL short_hold: got %h, want 00000932", word_of(50)); end
    checks++; if (frame_cnt !== 16'd2) begin errors++; $display("FAIL short_cnt: got %0d, want 2", frame_cnt); end
    send_beats(256, 255, 32'h200, 1'b0);
    checks++; if (v_cnt != 1 || e_cnt != 0) begin errors++; $display("FAIL short_next_pulses: valid %0d err %0d, want 1 0", v_cnt, e_cnt); end
    checks++; if (count_bad(32'h200) != 0) begin errors++; $display("FAIL short_next_words: %0d bad words, want 0", count_bad(32'h200)); end
    checks++; if (frame_cnt !== 16'd3) begin errors++; $display("FAIL short_next_cnt: got %0d, want 3", frame_cnt); end
  endtask

  task automatic test_long();
    send_beats(300, 299, 32'h7000, 1'b0);
    checks++; if (e_cnt != 1) begin errors++; $display("FAIL long_ecnt: got %0d, want 1", e_cnt); end
    checks++; if (e_at != 255) begin errors++; $display("FAIL long_eat: got %0d, want 255", e_at); end
    checks++; if (stalls != 0) begin errors++; $display("FAIL long_stalls: got %0d, want 0", stalls); end
    checks++; if (v_cnt != 0) begin errors++; $display("FAIL long_vcnt: got %0d, want 0", v_cnt); end
    checks++; if (count_bad(32'h200) != 0) begin errors++; $display("FAIL long_hold: %0d changed words, want 0", count_bad(32'h200)); end
    send_beats(256, 255, 32'h300, 1'b0);
    checks++; if (v_cnt != 1 || e_cnt != 0) begin errors++; $display("FAIL long_next_pulses: valid %0d err %0d, want 1 0", v_cnt, e_cnt); end
    checks++; if (word_of(255) !== 32'h3FF) begin errors++; $display("FAIL long_next_w255: got %h, want 000003ff", word_of(255)); end
    checks++; if (frame_cnt !== 16'd4) begin errors++; $display("FAIL long_next_cnt: got %0d, want 4", frame_cnt); end
  endtask

  task automatic test_reset_mid();
    send_beats(120, -1, 32'h6000, 1'b0);
    checks++; if (v_cnt != 0 || e_cnt != 0) begin errors++; $display("FAIL mid_pulses: valid %0d err %0d, want 0 0", v_cnt, e_cnt); end
    #2 rst = 1'b0;
    #1;
    checks++; if (M_AXIS_tready !== 1'b0) begin errors++; $display("FAIL mid_rst_tready: got %b, want 0", M_AXIS_tready); end
    checks++; if (frame_data !== '0) begin errors++; $display("FAIL mid_rst_data: got nonzero, want 0"); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL mid_rst_cnt: got %0d, want 0", frame_cnt); end
    @(negedge clk);
    rst = 1'b1;
    send_beats(256, 255, 32'h400, 1'b0);
    checks++; if (v_cnt != 1 || e_cnt != 0) begin errors++; $display("FAIL mid_next_pulses: valid %0d err %0d, want 1 0", v_cnt, e_cnt); end
    checks++; if (word_of(0) !== 32'h400) begin errors++; $display("FAIL mid_next_w0: got %h, want 00000400", word_of(0)); end
    checks++; if (count_bad(32'h400) != 0) begin errors++; $display("FAIL mid_next_words: %0d bad words, want 0", count_bad(32'h400)); end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL mid_next_cnt: got %0d, want 1", frame_cnt); end
  endtask

  task automatic test_enable_idle();
    enable = 1'b0;
    send_beats(256, 255, 32'hA00, 1'b0);
    checks++; if (v_cnt != 1) begin errors++; $display("FAIL en_vcnt: got %0d, want 1", v_cnt); end
    checks++; if (frame_cnt !== 16'd2) begin errors++; $display("FAIL en_cnt: got %0d, want 2", frame_cnt); end
    repeat (2) @(negedge clk);
    checks++; if (M_AXIS_tready !== 1'b0) begin errors++; $display("FAIL en_idle_tready: got %b, want 0", M_AXIS_tready); end
    enable = 1'b1;
    @(negedge clk);
    checks++; if (M_AXIS_tready !== 1'b1) begin errors++; $display("FAIL en_resume_tready: got %b, want 1", M_AXIS_tready); end
  endtask

  task automatic test_back_to_back();
    int hold_low = 0;
`ifdef FRAME_ACK_EN
    frame_ack = 1'b0;
    send_beats(256, 255, 32'hB00, 1'b0);
    checks++; if (v_cnt != 1) begin errors++; $display("FAIL b2b_first_vcnt: got %0d, want 1", v_cnt); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (M_AXIS_tready === 1'b0) hold_low++;
    end
    checks++; if (hold_low != 10) begin errors++; $display("FAIL b2b_hold: tready low %0d cycles, want 10", hold_low); end
    frame_ack = 1'b1;
    send_beats(256, 255, 32'hC00, 1'b0);
`else
    send_beats(256, 255, 32'hB00, 1'b0);
    checks++; if (v_cnt != 1) begin errors++; $display("FAIL b2b_first_vcnt: got %0d, want 1", v_cnt); end
    hold_low = stalls;
    send_beats(256, 255, 32'hC00, 1'b0);
    checks++; if (hold_low + stalls != 0) begin errors++; $display("FAIL b2b_stalls: got %0d, want 0", hold_low + stalls); end
`endif
    checks++; if (v_cnt != 1 || e_cnt != 0) begin errors++; $display("FAIL b2b_pulses: valid %0d err %0d, want 1 0", v_cnt, e_cnt); end
    checks++; if (word_of(128) !== 32'hC80) begin errors++; $display("FAIL b2b_w128: got %h, want 00000c80", word_of(128)); end
    checks++; if (count_bad(32'hC00) != 0) begin errors++; $display("FAIL b2b_words: %0d bad words, want 0", count_bad(32'hC00)); end
    checks++; if (frame_cnt !== 16'd4) begin errors++; $display("FAIL b2b_cnt: got %0d, want 4", frame_cnt); end
  endtask

  task automatic test_exclusive();
    checks++; if (both_cnt != 0) begin errors++; $display("FAIL excl: valid and err high together %0d times, want 0", both_cnt); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_gaps();
    test_short();
    test_long();
    test_reset_mid();
    test_enable_idle();
    test_back_to_back();
    test_exclusive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
